// File: rtl/seg_scan_reader_pkg.sv
// Shared constants for the 7-segment display path: segment encodings, BCD
// sentinel values and the scan-reader FSM state type.
package seg_scan_reader_pkg;

    // Active-high segment patterns, bits 6..0 = g..a. The display decoder
    // uses these same constants, so the drive and receive ends always agree.
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7C;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h67;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Values a digit register holds when the pattern is not a decimal digit.
    localparam logic [3:0] BCD_BLANK = 4'hF;
    localparam logic [3:0] BCD_BAD   = 4'hE;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        QUAL = 2'd1,
        HOLD = 2'd2
    } scan_state_t;

endpackage

// File: rtl/seg_pattern_to_bcd.sv
// Combinational reverse decoder: 7-bit segment pattern to BCD value.
// Blank returns BCD_BLANK, anything unrecognised returns BCD_BAD.
module seg_pattern_to_bcd
    import seg_scan_reader_pkg::*;
(
    input  logic [6:0] i_pattern,
    output logic [3:0] o_bcd,
    output logic       o_legal,
    output logic       o_blank
);

    // Exact-match lookup; no alternate glyphs (e.g. tailed 6/7/9) accepted.
    always_comb begin
        o_bcd   = BCD_BAD;
        o_legal = 1'b1;
        o_blank = 1'b0;
        case (i_pattern)
            SEG_0:     o_bcd = 4'd0;
            SEG_1:     o_bcd = 4'd1;
            SEG_2:     o_bcd = 4'd2;
            SEG_3:     o_bcd = 4'd3;
            SEG_4:     o_bcd = 4'd4;
            SEG_5:     o_bcd = 4'd5;
            SEG_6:     o_bcd = 4'd6;
            SEG_7:     o_bcd = 4'd7;
            SEG_8:     o_bcd = 4'd8;
            SEG_9:     o_bcd = 4'd9;
            SEG_BLANK: begin
                o_bcd   = BCD_BLANK;
                o_legal = 1'b0;
                o_blank = 1'b1;
            end
            default:   o_legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg_scan_reader.sv
// Monitors a multiplexed 7-segment bus, qualifies stable {select, pattern}
// pairs and decodes each captured digit back to BCD, one register per digit.
module seg_scan_reader
    import seg_scan_reader_pkg::*;
#(
    parameter int N_DIGITS      = 6,
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [7:0]            i_seg,
    input  logic [N_DIGITS-1:0]   i_digit_sel,
    input  logic                  i_err_clr,
    output logic [4*N_DIGITS-1:0] o_bcd,
    output logic [N_DIGITS-1:0]   o_valid,
    output logic [N_DIGITS-1:0]   o_dp,
    output logic                  o_frame_done,
    output logic                  o_err_pat,
    output logic                  o_err_sel
);

    localparam int                  PAIR_W  = N_DIGITS + 8;
    localparam logic [N_DIGITS-1:0] SEL_ONE = N_DIGITS'(1);
    localparam logic [CNT_W-1:0]    CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0]    CNT_TGT = CNT_W'(STABLE_CYCLES);

    logic [7:0]          r_seg;
    logic [N_DIGITS-1:0] r_sel;
    logic [PAIR_W-1:0]   pair;
    logic [PAIR_W-1:0]   cmp_q, cmp_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_inc;
    scan_state_t         state_q, state_d;
    logic                sel_onehot, sel_multi;
    logic                capture, sel_err, pat_err;
    logic [3:0]          dec_bcd;
    logic                dec_legal, dec_blank;
    logic [N_DIGITS-1:0] mask_q, mask_upd;

    seg_pattern_to_bcd u_dec (
        .i_pattern (r_seg[6:0]),
        .o_bcd     (dec_bcd),
        .o_legal   (dec_legal),
        .o_blank   (dec_blank)
    );

    // Single input register; every decision below looks only at r_seg/r_sel.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_seg <= '0;
            r_sel <= '0;
        end else begin
            r_seg <= i_seg;
            r_sel <= i_digit_sel;
        end
    end

    // Classify the registered select and derive helper terms.
    always_comb begin
        pair       = {r_sel, r_seg};
        sel_onehot = (r_sel != '0) && ((r_sel & (r_sel - SEL_ONE)) == '0);
        sel_multi  = (r_sel != '0) && !sel_onehot;
        cnt_inc    = cnt_q + CNT_ONE;
        mask_upd   = mask_q | r_sel;
        pat_err    = capture && !dec_legal && !dec_blank;
    end

    // Next-state logic: a changed pair always goes through the same entry
    // rules (one-hot loads and qualifies, zero idles, multi-hot flags).
    always_comb begin
        state_d = state_q;
        cmp_d   = cmp_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        sel_err = 1'b0;
        case (state_q)
            IDLE: begin
                if (sel_onehot) begin
                    cmp_d   = pair;
                    cnt_d   = CNT_ONE;
                    state_d = QUAL;
                end else begin
                    sel_err = sel_multi;
                end
            end
            QUAL, HOLD: begin
                if (pair == cmp_q) begin
                    if (state_q == QUAL) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == CNT_TGT) begin
                            capture = 1'b1;
                            state_d = HOLD;
                        end
                    end
                end else if (sel_onehot) begin
                    cmp_d   = pair;
                    cnt_d   = CNT_ONE;
                    state_d = QUAL;
                end else begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    sel_err = sel_multi;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // FSM state, compare register and stability counter.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            cmp_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cmp_q   <= cmp_d;
            cnt_q   <= cnt_d;
        end
    end

    // Per-digit capture registers plus frame mask and completion pulse.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_bcd        <= {N_DIGITS{BCD_BLANK}};
            o_valid      <= '0;
            o_dp         <= '0;
            mask_q       <= '0;
            o_frame_done <= 1'b0;
        end else begin
            o_frame_done <= 1'b0;
            if (capture) begin
                for (int unsigned k = 0; k < N_DIGITS; k++) begin
                    if (r_sel[k]) begin
                        o_bcd[4*k +: 4] <= dec_bcd;
                        o_valid[k]      <= dec_legal;
                        o_dp[k]         <= r_seg[7];
                    end
                end
                if (mask_upd == '1) begin
                    mask_q       <= '0;
                    o_frame_done <= 1'b1;
                end else begin
                    mask_q <= mask_upd;
                end
            end
        end
    end

    // Sticky error flags; a new error in the clearing cycle keeps the flag set.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_err_pat <= 1'b0;
            o_err_sel <= 1'b0;
        end else begin
            if (pat_err)
                o_err_pat <= 1'b1;
            else if (i_err_clr)
                o_err_pat <= 1'b0;
            if (sel_err)
                o_err_sel <= 1'b1;
            else if (i_err_clr)
                o_err_sel <= 1'b0;
        end
    end

endmodule

// File: tb/tb_seg_scan_reader.sv
// Self-checking bench for seg_scan_reader: run-length behavioural model with a
// per-cycle compare, plus directed vectors with hand-computed expectations.
module tb_seg_scan_reader;

    localparam int N = 6;
    localparam int S = 4;

    logic           clk     = 1'b0;
    logic           rst_n   = 1'b0;
    logic [7:0]     seg     = '0;
    logic [N-1:0]   sel     = '0;
    logic           err_clr = 1'b0;
    logic [4*N-1:0] o_bcd;
    logic [N-1:0]   o_valid;
    logic [N-1:0]   o_dp;
    logic           o_frame_done;
    logic           o_err_pat;
    logic           o_err_sel;

    seg_scan_reader #(
        .N_DIGITS      (N),
        .STABLE_CYCLES (S),
        .CNT_W         (8)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_seg        (seg),
        .i_digit_sel  (sel),
        .i_err_clr    (err_clr),
        .o_bcd        (o_bcd),
        .o_valid      (o_valid),
        .o_dp         (o_dp),
        .o_frame_done (o_frame_done),
        .o_err_pat    (o_err_pat),
        .o_err_sel    (o_err_sel)
    );

    always #10 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    logic [6:0] pat_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7C, 7'h07, 7'h7F, 7'h67};

    // Model: a one-hot pair is captured on the edge after it has been sampled
    // S times in a row (exactly once per run); any multi-hot sample flags an
    // error on the following edge.
    int           m_bcd   [N];
    bit           m_valid [N];
    bit           m_dp    [N];
    bit           m_mask  [N];
    bit           m_fd, m_epat, m_esel;
    logic [N+7:0] h1 = '0;
    int           run = 0;
    logic [N-1:0] hsel;
    logic [7:0]   hseg;
    bit           set_pat, set_sel, full;
    int           mk, val;

    initial begin
        for (int i = 0; i < N; i++) begin
            m_bcd[i] = 15; m_valid[i] = 0; m_dp[i] = 0; m_mask[i] = 0;
        end
        m_fd = 0; m_epat = 0; m_esel = 0;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                m_bcd[i] = 15; m_valid[i] = 0; m_dp[i] = 0; m_mask[i] = 0;
            end
            m_fd = 0; m_epat = 0; m_esel = 0;
            h1 = '0; run = 0;
        end else begin
            hsel    = h1[N+7:8];
            hseg    = h1[7:0];
            set_pat = 0;
            set_sel = ($countones(hsel) > 1);
            m_fd    = 0;
            if (run == S && $countones(hsel) == 1) begin
                mk = 0;
                for (int i = 0; i < N; i++) if (hsel[i]) mk = i;
                val = -1;
                for (int i = 0; i < 10; i++) if (pat_tab[i] == hseg[6:0]) val = i;
                if (val >= 0) begin
                    m_bcd[mk] = val; m_valid[mk] = 1;
                end else if (hseg[6:0] == 7'h00) begin
                    m_bcd[mk] = 15; m_valid[mk] = 0;
                end else begin
                    m_bcd[mk] = 14; m_valid[mk] = 0; set_pat = 1;
                end
                m_dp[mk]   = hseg[7];
                m_mask[mk] = 1;
                full = 1;
                for (int i = 0; i < N; i++) if (!m_mask[i]) full = 0;
                if (full) begin
                    m_fd = 1;
                    for (int i = 0; i < N; i++) m_mask[i] = 0;
                end
            end
            m_epat = set_pat ? 1'b1 : (err_clr ? 1'b0 : m_epat);
            m_esel = set_sel ? 1'b1 : (err_clr ? 1'b0 : m_esel);
            if ({sel, seg} == h1) run++;
            else begin
                run = 1;
                h1  = {sel, seg};
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    logic [4*N-1:0] e_bcd;
    logic [N-1:0]   e_valid, e_dp;
    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            e_bcd[4*i +: 4] = 4'(m_bcd[i]);
            e_valid[i]      = m_valid[i];
            e_dp[i]         = m_dp[i];
        end
        chk("model_bcd",   32'(o_bcd),   32'(e_bcd));
        chk("model_valid", 32'(o_valid), 32'(e_valid));
        chk("model_dp",    32'(o_dp),    32'(e_dp));
        chk("model_frame", 32'(o_frame_done), 32'(m_fd));
        chk("model_epat",  32'(o_err_pat),    32'(m_epat));
        chk("model_esel",  32'(o_err_sel),    32'(m_esel));
    end

    int fd_cnt = 0;
    always @(negedge clk) fd_cnt += int'(o_frame_done);

    task automatic drive(input logic [N-1:0] s, input logic [7:0] g, input int n);
        sel = s;
        seg = g;
        repeat (n) @(negedge clk);
    endtask

    logic [7:0]   scan_pat [N] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D};
    logic [N-1:0] one_sel;

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_bcd",   32'(o_bcd),   32'h00FF_FFFF);
        chk("rst_valid", 32'(o_valid), 32'h0);
        chk("rst_dp",    32'(o_dp),    32'h0);
        chk("rst_frame", 32'(o_frame_done), 32'h0);
        chk("rst_errs",  32'({o_err_pat, o_err_sel}), 32'h0);
        rst_n = 1'b1;
        drive('0, 8'h00, 2);

        // Pattern sweep on digit 0: not yet at edge 4, captured at edge 5.
        for (int v = 0; v < 10; v++) begin
            drive(6'b000001, {1'b0, pat_tab[v]}, 4);
            chk("sweep_edge4", 32'(o_bcd[3:0]), (v == 0) ? 32'hF : 32'(v - 1));
            drive(6'b000001, {1'b0, pat_tab[v]}, 1);
            chk("sweep_edge5", 32'(o_bcd[3:0]), 32'(v));
            chk("sweep_valid", 32'(o_valid[0]), 32'h1);
            drive('0, 8'h00, 2);
        end

        // Full scan of all digits: one frame pulse after the last capture.
        fd_cnt = 0;
        for (int k = 0; k < N; k++) begin
            one_sel = N'(1 << k);
            drive(one_sel, scan_pat[k], 8);
        end
        chk("scan_bcd",   32'(o_bcd),   32'h0054_3210);
        chk("scan_valid", 32'(o_valid), 32'h3F);
        chk("scan_pulses", 32'(fd_cnt), 32'h1);

        // Short glitch must not capture.
        drive(6'b000001, 8'h3F, 6);
        drive(6'b000001, 8'h06, 3);
        drive('0, 8'h00, 6);
        chk("glitch_bcd", 32'(o_bcd), 32'h0054_3210);

        // Illegal pattern, multi-hot select, then clearing.
        drive(6'b000100, 8'h7D, 6);
        chk("err_bcd",   32'(o_bcd[11:8]), 32'hE);
        chk("err_valid", 32'(o_valid[2]),  32'h0);
        chk("err_pat",   32'(o_err_pat),   32'h1);
        drive(6'b000011, 8'h3F, 3);
        chk("err_sel", 32'(o_err_sel), 32'h1);
        err_clr = 1'b1;
        drive(6'b000011, 8'h3F, 1);
        err_clr = 1'b0;
        chk("clr_sel_wins", 32'(o_err_sel), 32'h1);
        chk("clr_pat",      32'(o_err_pat), 32'h0);
        drive('0, 8'h00, 2);
        err_clr = 1'b1;
        drive('0, 8'h00, 1);
        err_clr = 1'b0;
        chk("clr_both", 32'({o_err_pat, o_err_sel}), 32'h0);

        // Blank with decimal point.
        drive(6'b010000, 8'h80, 6);
        chk("blank_bcd",   32'(o_bcd[19:16]), 32'hF);
        chk("blank_valid", 32'(o_valid[4]),   32'h0);
        chk("blank_dp",    32'(o_dp[4]),      32'h1);
        chk("blank_epat",  32'(o_err_pat),    32'h0);

        // Reset while qualifying (counter at 3).
        drive(6'b001000, 8'h07, 4);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_bcd",   32'(o_bcd),   32'h00FF_FFFF);
        chk("midrst_valid", 32'(o_valid), 32'h0);
        chk("midrst_dp",    32'(o_dp),    32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("postrst_edge4", 32'(o_bcd[15:12]), 32'hF);
        @(negedge clk);
        chk("postrst_edge5", 32'(o_bcd[15:12]), 32'h7);
        chk("postrst_valid", 32'(o_valid[3]),   32'h1);
        drive('0, 8'h00, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seg_scan_reader.md
Name: seg_scan_reader

Overview:
- Receive-side counterpart of the stopwatch 7-segment drive path.
- Monitors the multiplexed display bus (segment pattern plus one-hot digit select).
- Qualifies stable samples and decodes each pattern back to BCD, keeping one BCD register per digit position.
- Used for display loopback self-check on the board and as a scoreboard front-end in the stopwatch bench.

Parameters:
- N_DIGITS, 6, number of multiplexed digit positions (mm:ss:cc).
- STABLE_CYCLES, 4, consecutive identical samples (2..255) required before a capture.
- CNT_W, 8, width of the stability counter; must hold STABLE_CYCLES.

Ports:
- i_clk  input  1  system clock, 50 MHz.
- i_rst_n  input  1  reset, asynchronous, active-low.
- i_seg  input  8  segment pattern, active-high; bit7 = dp, bits6..0 = g..a.
- i_digit_sel  input  N_DIGITS  digit enable, active-high, expected one-hot or all-zero.
- i_err_clr  input  1  synchronous clear of both sticky error flags.
- o_bcd  output  4*N_DIGITS  decoded digit k in bits [4k+3:4k].
- o_valid  output  N_DIGITS  digit k holds a legal decimal value.
- o_dp  output  N_DIGITS  captured dp bit per digit.
- o_frame_done  output  1  one-cycle pulse when every digit has been captured since the last pulse.
- o_err_pat  output  1  sticky: non-blank illegal pattern captured.
- o_err_sel  output  1  sticky: more than one select bit high.

Behaviour:
- One clock domain; i_clk and i_rst_n named as elsewhere in the codebase. Reset is asynchronous, active-low.
- Reset values:
  - o_bcd = all 4'hF.
  - o_valid, o_dp, o_frame_done, o_err_pat, o_err_sel = 0.
  - Frame mask = 0; FSM = IDLE; counter = 0.
- Input register: i_seg and i_digit_sel registered once (r_seg, r_sel). All decisions use the registered values.
- Legal patterns, bits6..0 (exact match; no alternates accepted):
  - 0=7'h3F, 1=7'h06, 2=7'h5B, 3=7'h4F, 4=7'h66
  - 5=7'h6D, 6=7'h7C, 7=7'h07, 8=7'h7F, 9=7'h67
- Pattern handling at capture:
  - Legal pattern: value written to o_bcd[k], o_valid[k] = 1.
  - 7'h00 (blank): o_bcd[k] = 4'hF, o_valid[k] = 0, no error.
  - Any other pattern: o_bcd[k] = 4'hE, o_valid[k] = 0, o_err_pat set.
  - o_dp[k] = r_seg[7] in all three cases.
- FSM states:
  - IDLE: r_sel == 0. If r_sel is one-hot, load the compare register with {r_sel, r_seg}, set counter = 1, go QUAL. If more than one bit is high, set o_err_sel and stay IDLE.
  - QUAL: if {r_sel, r_seg} equals the compare register, increment the counter.
    - Counter reaches STABLE_CYCLES: capture into digit k = index of the r_sel bit, set mask[k], go HOLD.
    - Pair differs and is a legal one-hot: reload the compare register, counter = 1, stay QUAL.
    - Pair differs and r_sel is zero or multi-hot: go IDLE (multi-hot also sets o_err_sel).
  - HOLD: no recapture while the pair is unchanged. On any change, apply the IDLE entry rules to the new pair.
- Latency: o_bcd[k] updates STABLE_CYCLES+1 edges after i_seg/i_digit_sel change, counted from the first edge that samples the new value.
- Frame mask:
  - When the mask would become all ones, o_frame_done pulses on the next edge and the mask clears in the same edge.
  - Recapturing a digit already in the mask does not pulse.
- Sticky errors: cleared by i_err_clr. If i_err_clr and a new error occur in the same cycle, the error wins (flag stays 1).
- Glitches shorter than STABLE_CYCLES never update outputs.
- Reset mid-QUAL discards the partial count with no capture.

Decomposition:
- Shared package holds:
  - Constants SEG_0..SEG_9, SEG_BLANK, BCD_BLANK = 4'hF, BCD_BAD = 4'hE.
  - FSM state encoding (IDLE, QUAL, HOLD).
  - These segment constants are shared with the existing segment decoder so both ends stay in lockstep.
- One sub-module: seg_pattern_to_bcd, combinational 7-bit pattern to {bcd, legal, blank}.
- FSM, counter, mask and per-digit registers live in the top.

Test Plan:
- Pattern sweep: hold sel=6'b000001 and i_seg=8'h5B for 6 cycles -> o_bcd[3:0]=4'h2, o_valid[0]=1 at edge 5; repeat for all ten codes.
- Full scan: drive digits 0..5 as 8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, each held 8 cycles -> o_bcd=24'h543210, o_frame_done exactly one pulse after digit 5 capture.
- Glitch: stable 8'h3F, then a 3-cycle 8'h06 burst with STABLE_CYCLES=4 -> o_bcd unchanged, no capture.
- Errors: i_seg=8'h7D on digit 2 -> o_bcd[11:8]=4'hE, o_err_pat=1. Then sel=6'b000011 -> o_err_sel=1. Then i_err_clr pulse -> both flags 0.
- Blank and dp: i_seg=8'h80 on digit 4 -> o_bcd[19:16]=4'hF, o_valid[4]=0, o_dp[4]=1, o_err_pat=0.
- Reset: assert i_rst_n=0 during QUAL (counter=3) -> all outputs at reset values immediately; no capture after release until STABLE_CYCLES fresh samples.
